aes_key_schedule: RTL and testbench
===================================

# aes_key_schedule

Iterative AES-128 key expansion stage that sits directly downstream of the SPI shift interface. It consumes the 128-bit `key` that the SPI block delivers and produces the eleven round keys (round 0..10) one at a time, on demand, for the AES round datapath. It computes one round key per advance request with a single registered 128-bit state, so no key RAM is needed.

## Interface
Parameters:
- none (AES-128 only; Nk=4, Nr=10 fixed)

Ports:
- `clk`  in  1  core clock; all state updates on posedge.
- `reset_n`  in  1  synchronous, active-low reset; sampled on posedge `clk`.
- `start`  in  1  single-cycle request: capture `key` and begin at round 0.
- `key`  in  128  cipher key, byte 0 = `key[127:120]`; word w0 = `key[127:96]`.
- `next`  in  1  advance request: compute the following round key.
- `round_key`  out  128  current round key, same byte/word ordering as `key`.
- `round`  out  4  index of the round key presented (0..10).
- `key_valid`  out  1  `round_key` and `round` are valid.
- `last`  out  1  high while `round`==10 and `key_valid`.

## Operation
- States: IDLE, ACTIVE, FINAL.
- IDLE: `key_valid`=0 and `next` is ignored. When `start`=1, go to ACTIVE with `round_key`=`key` and `round`=0.
- ACTIVE: `key_valid`=1. When `next`=1, load the expanded key, increment `round`, and update the Rcon register. Go to FINAL when the new round is 10.
- FINAL: `key_valid`=1 and `last`=1. `next` is ignored, and `round_key`/`round` hold until `start` or reset.
- Expansion, with w0..w3 taken as the current 32-bit words (MSB first):
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}; RotWord rotates left by one byte.
  - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
- SubWord applies the FIPS-197 forward S-box to each of the 4 bytes. Implement it as 4 combinational S-box instances, as a case table or GF(2^8) inverse plus affine.
- Rcon register sequence: 01,02,04,08,10,20,40,80,1B,36.
  - Update rule is xtime: shift left by one; if bit 7 was set, XOR with 1B.
  - Reset to 01 on `start`.
- `start` is accepted in every state and always restarts at round 0 from the `key` present in that cycle. `start` has priority over `next`.
- Reset (`reset_n`=0) has priority over everything. Reset values: state=IDLE, `round_key`=0, `round`=0, `key_valid`=0, `last`=0, rcon=01.
- `key` is sampled only on the `start` cycle. Later changes on the SPI shift register do not disturb the schedule.

## Timing
- `start` at edge N: `key_valid`=1, `round`=0 and `round_key`=`key` are visible after edge N (in cycle N+1).
- `next` at edge M while ACTIVE: the new key and `round`+1 are visible in cycle M+1. Latency is 1 cycle and throughput is 1 key/cycle with `next` held high.
- With `next` held continuously from the cycle after `start`, round 10 is presented 11 cycles after `start` and `last` rises in that same cycle.
- All outputs are registered, except that `last` may be decoded from registered state.
- No combinational path exists from `next`/`start` to any output.
- Critical path: S-box, then XOR chain of 4 words, then register.

## Test plan
- FIPS-197 App. A: `start` with key 2b7e151628aed2a6abf7158809cf4f3c, then `next` held high. Required response:
  - round 1 = a0fafe1788542cb123a339392a6c7605
  - round 2 = f2c295f27a96b9435935807a7359f67f
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with `last`=1 in that cycle.
- Zero key: `start` with key 0 and `next` pulsed every 3rd cycle. Required response:
  - round 1 = 62636363626363636263636362636363
  - round 10 = b4ef5bcb3e92e21123e951cf6f8f188e
  - `round_key` holds between pulses.
- FINAL hold: after round 10, assert `next` for 5 cycles. `round` stays 10, `round_key` is unchanged and `key_valid` stays 1.
- Restart mid-schedule: at round 4, assert `start` and `next` together with the App. A key. Next cycle shows `round`=0 and `round_key`=2b7e…4f3c; the next `next` gives round 1 = a0fafe17….
- Reset mid-operation: pull `reset_n` low at round 6 while `next`=1. Next cycle shows `key_valid`=0, `round`=0, `round_key`=0, `last`=0. `next` is then ignored until `start`.
- Idle ignore: after reset, pulse `next` with no `start`. Outputs stay at their reset values.

Source files
------------

// File: rtl/aes_key_schedule.sv
// aes_key_schedule
//   Iterative AES-128 key expansion. It captures a 128-bit cipher key on
//   start and then produces round keys 0..10 one at a time. Each next
//   request advances one round. A single 128-bit state register holds the
//   current round key, so no key storage is needed.
//
// Ports
//   clk        core clock, all state updates on posedge
//   reset_n    synchronous active-low reset
//   start      capture key and restart at round 0 (has priority over next)
//   key        cipher key, byte 0 = key[127:120], w0 = key[127:96]
//   next       advance to the following round key
//   round_key  current round key, same ordering as key
//   round      index of the presented round key (0..10)
//   key_valid  round_key/round are valid
//   last       round 10 is being presented
//
// state  | meaning
// IDLE   | no key loaded, next ignored
// ACTIVE | rounds 0..9 presented, next advances
// FINAL  | round 10 presented and held, next ignored
module aes_key_schedule (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] key,
    input  logic         next,
    output logic [127:0] round_key,
    output logic [3:0]   round,
    output logic         key_valid,
    output logic         last
);

    typedef enum logic [1:0] {IDLE, ACTIVE, FINAL} state_t;

    state_t       state, state_nxt;
    logic [7:0]   rcon, rcon_nxt;
    logic [127:0] rk_nxt;
    logic [3:0]   round_nxt;
    logic         valid_nxt;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot, t;
    logic [31:0]  n0, n1, n2, n3;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box: multiplicative inverse as a^254 (0 maps to 0), then
    // the affine transform expressed as XOR of byte rotations plus 0x63.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = a;
        // 254 = 2+4+8+16+32+64+128
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    assign w0  = round_key[127:96];
    assign w1  = round_key[95:64];
    assign w2  = round_key[63:32];
    assign w3  = round_key[31:0];
    assign rot = {w3[23:0], w3[31:24]};
    assign t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                 ^ {rcon, 24'h000000};
    assign n0  = w0 ^ t;
    assign n1  = w1 ^ n0;
    assign n2  = w2 ^ n1;
    assign n3  = w3 ^ n2;

    always_comb begin
        state_nxt = state;
        rk_nxt    = round_key;
        round_nxt = round;
        rcon_nxt  = rcon;
        valid_nxt = key_valid;
        if (start) begin
            state_nxt = ACTIVE;
            rk_nxt    = key;
            round_nxt = 4'd0;
            rcon_nxt  = 8'h01;
            valid_nxt = 1'b1;
        end else begin
            case (state)
                ACTIVE: begin
                    if (next) begin
                        rk_nxt    = {n0, n1, n2, n3};
                        round_nxt = round + 4'd1;
                        rcon_nxt  = xtime(rcon);
                        if (round == 4'd9) state_nxt = FINAL;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            round_key <= 128'h0;
            round     <= 4'd0;
            key_valid <= 1'b0;
            rcon      <= 8'h01;
        end else begin
            state     <= state_nxt;
            round_key <= rk_nxt;
            round     <= round_nxt;
            key_valid <= valid_nxt;
            rcon      <= rcon_nxt;
        end
    end

    assign last = (state == FINAL);

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule
//   Self-checking bench for aes_key_schedule. A reference model computes the
//   full FIPS-197 word expansion from an S-box table and an Rcon table. It
//   then tracks round/valid at transaction level. Directed FIPS-197 vectors
//   are followed by randomized start/next/reset traffic.
module tb_aes_key_schedule;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [127:0] key;
    logic         next;
    logic [127:0] round_key;
    logic [3:0]   round;
    logic         key_valid;
    logic         last;

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [127:0] KA   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R1A  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R2A  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] R10A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R1Z  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] R10Z = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    localparam logic [2047:0] SBOX_P = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [79:0] RCON_P = 80'h01020408102040801b36;

    logic [127:0] m_sched [0:10];
    logic         m_valid;
    int           m_round;

    aes_key_schedule dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .key       (key),
        .next      (next),
        .round_key (round_key),
        .round     (round),
        .key_valid (key_valid),
        .last      (last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX_P[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic expand_key(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sub_byte(tmp[31:24]), sub_byte(tmp[23:16]),
                       sub_byte(tmp[15:8]), sub_byte(tmp[7:0])};
                tmp = tmp ^ {RCON_P[79 - 8*(i/4 - 1) -: 8], 24'h0};
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) m_sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    // One clock: apply inputs, advance model at the edge, check all outputs.
    task automatic cyc(input logic rs, input logic st, input logic nx, input logic [127:0] k);
        logic [127:0] exp_rk;
        reset_n = rs;
        start   = st;
        next    = nx;
        key     = k;
        @(posedge clk);
        if (!rs) begin
            m_valid = 1'b0;
            m_round = 0;
        end else if (st) begin
            expand_key(k);
            m_valid = 1'b1;
            m_round = 0;
        end else if (nx && m_valid && m_round < 10) begin
            m_round++;
        end
        #1;
        exp_rk = m_valid ? m_sched[m_round] : 128'h0;
        check("round_key", round_key, exp_rk);
        check("round", {124'h0, round}, 128'(m_round));
        check("key_valid", {127'h0, key_valid}, {127'h0, m_valid});
        check("last", {127'h0, last}, {127'h0, (m_valid && m_round == 10)});
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        next    = 1'b0;
        key     = '0;
        m_valid = 1'b0;
        m_round = 0;
        for (int r = 0; r < 11; r++) m_sched[r] = '0;

        cyc(0, 0, 0, '0);
        cyc(0, 0, 1, rand128());

        // next with no start does nothing
        repeat (3) cyc(1, 0, 1, rand128());

        // FIPS-197 App. A, next held high, key bus scrambled after start
        cyc(1, 1, 0, KA);
        check("fips_r0", round_key, KA);
        for (int r = 1; r <= 10; r++) begin
            cyc(1, 0, 1, rand128());
            if (r == 1)  check("fips_r1", round_key, R1A);
            if (r == 2)  check("fips_r2", round_key, R2A);
            if (r == 10) begin
                check("fips_r10", round_key, R10A);
                check("fips_last", {127'h0, last}, 128'h1);
            end
        end

        // FINAL hold with next asserted
        repeat (5) begin
            cyc(1, 0, 1, rand128());
            check("final_hold_rk", round_key, R10A);
            check("final_hold_round", {124'h0, round}, 128'd10);
        end

        // restart at round 4 with start and next together
        cyc(1, 1, 0, rand128());
        repeat (4) cyc(1, 0, 1, rand128());
        check("pre_restart_round", {124'h0, round}, 128'd4);
        cyc(1, 1, 1, KA);
        check("restart_r0", round_key, KA);
        check("restart_round0", {124'h0, round}, 128'd0);
        cyc(1, 0, 1, rand128());
        check("restart_r1", round_key, R1A);

        // zero key, next pulsed every third cycle
        cyc(1, 1, 0, 128'h0);
        for (int r = 1; r <= 10; r++) begin
            cyc(1, 0, 1, rand128());
            cyc(1, 0, 0, rand128());
            cyc(1, 0, 0, rand128());
            if (r == 1)  check("zero_r1", round_key, R1Z);
            if (r == 10) check("zero_r10", round_key, R10Z);
        end

        // reset at round 6 while next is high, then next ignored
        cyc(1, 1, 0, rand128());
        repeat (6) cyc(1, 0, 1, rand128());
        cyc(0, 0, 1, rand128());
        check("mid_reset_rk", round_key, 128'h0);
        repeat (3) cyc(1, 0, 1, rand128());

        // randomized traffic
        cyc(1, 1, 0, rand128());
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 63) != 0),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 3) != 0),
                rand128());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
